// File: rtl/uar_pkg.sv
// Shared constants, per-channel output bundle and counter sizing for the UART
// input synchroniser/filter.
package uar_pkg;

  localparam logic UAR_IDLE_LVL        = 1'b1;
  localparam int   UAR_SYNC_MIN_STAGES = 2;

  typedef struct packed {
    logic sync;
    logic filt;
    logic rise;
    logic fall;
  } uar_chan_out_t;

  // A single-cycle filter still needs a 1-bit counter so the port is never zero-width.
  function automatic int uar_cnt_width(input int filt_len);
    return (filt_len > 2) ? $clog2(filt_len) : 1;
  endfunction

endpackage : uar_pkg

// File: rtl/uar_sync_filter_if.sv
// Pin-side bus of the multi-channel synchroniser: raw asynchronous inputs and
// the synchronised, filtered and edge-pulse outputs.
interface uar_sync_filter_if #(
  parameter int WIDTH = 1
);

  logic [WIDTH-1:0] AsyncIn;
  logic [WIDTH-1:0] SyncOut;
  logic [WIDTH-1:0] FiltOut;
  logic [WIDTH-1:0] RiseOut;
  logic [WIDTH-1:0] FallOut;

  modport master (output AsyncIn, input SyncOut, FiltOut, RiseOut, FallOut);
  modport slave  (input AsyncIn, output SyncOut, FiltOut, RiseOut, FallOut);

endinterface : uar_sync_filter_if

// File: rtl/uar_sync_chan.sv
// One channel: STAGES-deep synchroniser, stable-count glitch filter and, when
// UAR_SYNC_EDGE_EN is defined, rise/fall pulses on the filtered level.
module uar_sync_chan
  import uar_pkg::*;
#(
  parameter int   STAGES   = UAR_SYNC_MIN_STAGES,
  parameter int   FILT_LEN = 4,
  parameter logic RST_VAL  = UAR_IDLE_LVL
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          async_i,
  output uar_chan_out_t out_o
);

  localparam int               CNT_W   = uar_cnt_width(FILT_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_LEN - 1);

  logic [STAGES-1:0] sync_q;
  logic              sync_out;
  logic              filt_q, filt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rise, fall;

  assign sync_out = sync_q[STAGES-1];

  // NOTE: a new level is only accepted once it has been seen on CNT_MAX+1
  // consecutive cycles; every write below has a default first so no latch forms.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_out != filt_q) begin
      if (cnt_q == CNT_MAX) begin
        filt_d = sync_out;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: the synchroniser flops take RST_VAL too, so the line looks idle
  // straight out of reset instead of replaying stale pin history.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RST_VAL}};
      filt_q <= RST_VAL;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

`ifdef UAR_SYNC_EDGE_EN
  logic prev_q;

  // Reset loads prev_q with the same level as filt_q, so reset never pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) prev_q <= RST_VAL;
    else       prev_q <= filt_q;
  end

  assign rise = filt_q & ~prev_q;
  assign fall = ~filt_q & prev_q;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

  assign out_o = '{sync: sync_out, filt: filt_q, rise: rise, fall: fall};

endmodule : uar_sync_chan

// File: rtl/uar_sync_filter.sv
// Multi-channel pin synchroniser and debounce filter; a thin fan-out over
// uar_sync_chan. Edge pulses are built only with UAR_SYNC_EDGE_EN defined.
module uar_sync_filter
  import uar_pkg::*;
#(
  parameter int               WIDTH    = 1,
  parameter int               STAGES   = UAR_SYNC_MIN_STAGES,
  parameter int               FILT_LEN = 4,
  parameter logic [WIDTH-1:0] RST_VAL  = {WIDTH{UAR_IDLE_LVL}}
) (
  input logic              Clk,
  input logic              Rst,
  uar_sync_filter_if.slave bus
);

  if (STAGES < UAR_SYNC_MIN_STAGES || FILT_LEN < 1) begin : g_bad_param
    $fatal(1, "uar_sync_filter: STAGES must be >= 2 and FILT_LEN >= 1");
  end

  uar_chan_out_t chan_out [WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    uar_sync_chan #(
      .STAGES   (STAGES),
      .FILT_LEN (FILT_LEN),
      .RST_VAL  (RST_VAL[i])
    ) u_chan (
      .clk_i   (Clk),
      .rst_i   (Rst),
      .async_i (bus.AsyncIn[i]),
      .out_o   (chan_out[i])
    );

    assign bus.SyncOut[i] = chan_out[i].sync;
    assign bus.FiltOut[i] = chan_out[i].filt;
    assign bus.RiseOut[i] = chan_out[i].rise;
    assign bus.FallOut[i] = chan_out[i].fall;
  end

endmodule : uar_sync_filter
